exe_stage_unit: RTL

- Execute-stage consumer of the decoder's control bundle: exe_cmd, wb_enable, mem_read, mem_write and status_write_enable.
- Combinational ALU; NZCV status register updated on S-instructions.
- EXE/MEM pipeline register with freeze (hazard stall) and flush (taken branch).
- Sits between the ID/EXE register and the memory stage; the status output feeds the ID-stage condition check.

---
 rtl/exe_stage_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exe_stage_unit.sv
// Execute stage: combinational ALU, NZCV status register and EXE/MEM pipeline register.
// Optional EXE_STATUS_BYPASS_EN forwards the post-update status combinationally during a status write.
module exe_stage_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [3:0]            exe_cmd,
    input  logic                  wb_en_in,
    input  logic                  mem_r_in,
    input  logic                  mem_w_in,
    input  logic                  s_in,
    input  logic [DATA_W-1:0]     val1,
    input  logic [DATA_W-1:0]     val2,
    input  logic [DATA_W-1:0]     st_val_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic [3:0]            status,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     st_val_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic                  wb_en_out,
    output logic                  mem_r_out,
    output logic                  mem_w_out,
    output logic                  valid_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [3:0]        status_q;
    logic [3:0]        status_next;
    logic              status_wr;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum;
    logic              cin;
    logic              arith;
    logic              cmd_defined;
    logic              flag_c;
    logic              flag_v;

    // Subtraction is folded into the adder as val1 + ~val2 + cin, so carry-out is NOT borrow.
    always_comb begin
        op_b        = '0;
        cin         = 1'b0;
        arith       = 1'b0;
        cmd_defined = 1'b1;
        alu_res     = '0;
        case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD: begin op_b = val2;  cin = 1'b0;        arith = 1'b1; end
            CMD_ADC: begin op_b = val2;  cin = status_q[1]; arith = 1'b1; end
            CMD_SUB: begin op_b = ~val2; cin = 1'b1;        arith = 1'b1; end
            CMD_SBC: begin op_b = ~val2; cin = status_q[1]; arith = 1'b1; end
            CMD_AND: alu_res = val1 & val2;
            CMD_ORR: alu_res = val1 | val2;
            CMD_EOR: alu_res = val1 ^ val2;
            default: cmd_defined = 1'b0;
        endcase
        sum = {1'b0, val1} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
        if (arith) alu_res = sum[DATA_W-1:0];
    end

    always_comb begin
        flag_c = status_q[1];
        flag_v = status_q[0];
        if (arith) begin
            flag_c = sum[DATA_W];
            flag_v = (val1[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != val1[DATA_W-1]);
        end
        status_next = cmd_defined ? {alu_res[DATA_W-1], (alu_res == '0), flag_c, flag_v} : status_q;
    end

    assign status_wr = valid_in & s_in & ~freeze & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= '0;
        else if (status_wr) status_q <= status_next;
    end

`ifdef EXE_STATUS_BYPASS_EN
    assign status = status_wr ? status_next : status_q;
`else
    assign status = status_q;
`endif

    // Flush clears control only; data fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_out <= '0;
            st_val_out  <= '0;
            dest_out    <= '0;
            wb_en_out   <= 1'b0;
            mem_r_out   <= 1'b0;
            mem_w_out   <= 1'b0;
            valid_out   <= 1'b0;
        end else if (flush) begin
            wb_en_out   <= 1'b0;
            mem_r_out   <= 1'b0;
            mem_w_out   <= 1'b0;
            valid_out   <= 1'b0;
        end else if (!freeze) begin
            alu_res_out <= alu_res;
            st_val_out  <= st_val_in;
            dest_out    <= dest_in;
            wb_en_out   <= wb_en_in & valid_in;
            mem_r_out   <= mem_r_in & valid_in;
            mem_w_out   <= mem_w_in & valid_in;
            valid_out   <= valid_in;
        end
    end

endmodule
